// File: rtl/hamming_pkg.sv
// Shared Hamming (7,4) definitions: FSM state encoding, codeword bit positions
// and the syndrome function used by both the encoder and the decoder.
package hamming_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_DEC  = 2'd1,
        ST_OUT  = 2'd2
    } state_e;

    localparam int CODE_W = 7;
    localparam int DATA_W = 4;
    localparam int SYN_W  = 3;

    // code[7-p] holds Hamming position p.
    localparam int P1_BIT = 6;
    localparam int P2_BIT = 5;
    localparam int D1_BIT = 4;
    localparam int P4_BIT = 3;
    localparam int D2_BIT = 2;
    localparam int D3_BIT = 1;
    localparam int D4_BIT = 0;

    // Returns {s4,s2,s1}; a non-zero value is the position of a single flipped bit.
    function automatic logic [SYN_W-1:0] syndrome74(input logic [CODE_W-1:0] code);
        logic s1;
        logic s2;
        logic s4;
        s1 = code[P1_BIT] ^ code[D1_BIT] ^ code[D2_BIT] ^ code[D4_BIT];
        s2 = code[P2_BIT] ^ code[D1_BIT] ^ code[D3_BIT] ^ code[D4_BIT];
        s4 = code[P4_BIT] ^ code[D2_BIT] ^ code[D3_BIT] ^ code[D4_BIT];
        return {s4, s2, s1};
    endfunction

endpackage

// File: rtl/hamming74_decode.sv
// Combinational Hamming (7,4) decoder: computes the syndrome, flips the single
// addressed bit and extracts the data nibble {D1,D2,D3,D4}.
module hamming74_decode
    import hamming_pkg::*;
(
    input  logic [CODE_W-1:0] code,
    output logic [DATA_W-1:0] data,
    output logic [SYN_W-1:0]  syndrome,
    output logic              corrected
);

    logic [CODE_W-1:0] fixed_code;
    logic [SYN_W-1:0]  flip_idx;

    // NOTE: every output of a combinational block gets a default on entry, so no path can leave one unassigned and infer a latch.
    always_comb begin
        syndrome   = syndrome74(code);
        corrected  = (syndrome != '0);
        flip_idx   = 3'd7 - syndrome;
        fixed_code = code;
        if (corrected) begin
            fixed_code[flip_idx] = ~code[flip_idx];
        end
        data = {fixed_code[D1_BIT], fixed_code[D2_BIT], fixed_code[D3_BIT], fixed_code[D4_BIT]};
    end

endmodule

// File: rtl/hamming_decode_arbiter.sv
// Round-robin arbiter sharing one Hamming (7,4) decode/correct datapath among
// NUM_CH valid/ready channels, with a tagged output and a saturating error count.
module hamming_decode_arbiter
    import hamming_pkg::*;
#(
    parameter  int NUM_CH = 4,
    parameter  int CNT_W  = 16,
    localparam int CH_W   = $clog2(NUM_CH)
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [NUM_CH-1:0]        req_valid,
    input  logic [CODE_W*NUM_CH-1:0] req_code,
    output logic [NUM_CH-1:0]        req_ready,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [DATA_W-1:0]        out_data,
    output logic [CH_W-1:0]          out_ch,
    output logic                     out_corrected,
    output logic [SYN_W-1:0]         out_syndrome,
    input  logic                     err_clr,
    output logic [CNT_W-1:0]         err_count
);

    localparam logic [CH_W:0]   CH_CNT  = (CH_W+1)'(NUM_CH);
    localparam logic [CH_W-1:0] LAST_CH = CH_W'(NUM_CH - 1);

    state_e state_q, state_d;

    logic [CH_W-1:0]   ptr_q, ptr_d;
    logic [CH_W-1:0]   ch_q, ch_d;
    logic [CODE_W-1:0] code_q, code_d;

    logic              out_valid_q, out_valid_d;
    logic [DATA_W-1:0] out_data_q, out_data_d;
    logic [CH_W-1:0]   out_ch_q, out_ch_d;
    logic              out_corrected_q, out_corrected_d;
    logic [SYN_W-1:0]  out_syndrome_q, out_syndrome_d;
    logic [CNT_W-1:0]  err_count_q, err_count_d;

    logic              grant_found;
    logic [CH_W-1:0]   grant_idx;
    logic [CH_W:0]     arb_sum;
    logic              in_fire;
    logic              out_fire;

    logic [DATA_W-1:0] dec_data;
    logic [SYN_W-1:0]  dec_syndrome;
    logic              dec_corrected;

    // Round-robin search starting at ptr_q, wrapping modulo NUM_CH.
    always_comb begin
        grant_found = 1'b0;
        grant_idx   = '0;
        arb_sum     = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            arb_sum = {1'b0, ptr_q} + (CH_W+1)'(i);
            if (arb_sum >= CH_CNT) begin
                arb_sum = arb_sum - CH_CNT;
            end
            if (!grant_found && req_valid[arb_sum[CH_W-1:0]]) begin
                grant_found = 1'b1;
                grant_idx   = arb_sum[CH_W-1:0];
            end
        end
    end

    // Handshakes are suppressed while rst is high so nothing completes in a reset cycle.
    assign in_fire  = (state_q == ST_IDLE) && grant_found && !rst;
    assign out_fire = (state_q == ST_OUT) && out_ready && !rst;

    // FSM state register.
    // NOTE: sequential state is assigned with <= so every flop samples pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM next-state logic.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: if (grant_found) state_d = ST_DEC;
            ST_DEC:  state_d = ST_OUT;
            ST_OUT:  if (out_ready) state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    // FSM outputs: one-hot grant only to a valid channel while idle.
    always_comb begin
        req_ready = '0;
        if (in_fire) begin
            req_ready[grant_idx] = 1'b1;
        end
    end

    hamming74_decode u_decode (
        .code      (code_q),
        .data      (dec_data),
        .syndrome  (dec_syndrome),
        .corrected (dec_corrected)
    );

    always_comb begin
        ptr_d           = ptr_q;
        ch_d            = ch_q;
        code_d          = code_q;
        out_valid_d     = out_valid_q;
        out_data_d      = out_data_q;
        out_ch_d        = out_ch_q;
        out_corrected_d = out_corrected_q;
        out_syndrome_d  = out_syndrome_q;
        err_count_d     = err_count_q;

        if (in_fire) begin
            code_d = req_code[CODE_W*int'(grant_idx) +: CODE_W];
            ch_d   = grant_idx;
            ptr_d  = (grant_idx == LAST_CH) ? '0 : grant_idx + 1'b1;
        end

        if (state_q == ST_DEC) begin
            out_valid_d     = 1'b1;
            out_data_d      = dec_data;
            out_ch_d        = ch_q;
            out_corrected_d = dec_corrected;
            out_syndrome_d  = dec_syndrome;
        end

        if (out_fire) begin
            out_valid_d = 1'b0;
        end

        // Clear has priority over a same-cycle increment.
        if (err_clr) begin
            err_count_d = '0;
        end else if (out_fire && out_corrected_q && (err_count_q != '1)) begin
            err_count_d = err_count_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ptr_q           <= '0;
            out_valid_q     <= 1'b0;
            out_data_q      <= '0;
            out_ch_q        <= '0;
            out_corrected_q <= 1'b0;
            out_syndrome_q  <= '0;
            err_count_q     <= '0;
        end else begin
            ptr_q           <= ptr_d;
            out_valid_q     <= out_valid_d;
            out_data_q      <= out_data_d;
            out_ch_q        <= out_ch_d;
            out_corrected_q <= out_corrected_d;
            out_syndrome_q  <= out_syndrome_d;
            err_count_q     <= err_count_d;
        end
    end

    // NOTE: the capture register carries no reset; it is always reloaded by a grant before the decoder result is used.
    always_ff @(posedge clk) begin
        code_q <= code_d;
        ch_q   <= ch_d;
    end

    assign out_valid     = out_valid_q;
    assign out_data      = out_data_q;
    assign out_ch        = out_ch_q;
    assign out_corrected = out_corrected_q;
    assign out_syndrome  = out_syndrome_q;
    assign err_count     = err_count_q;

endmodule

// File: tb/tb_hamming_decode_arbiter.sv
// Directed bench for hamming_decode_arbiter: expected words are built from an
// independent encoder and a known flip position, queued at send and checked at output.
module tb_hamming_decode_arbiter;

    localparam int NUM_CH = 4;
    localparam int CNT_W  = 7;
    localparam int CH_W   = 2;

    logic                 clk = 1'b0;
    logic                 rst = 1'b1;
    logic [NUM_CH-1:0]    req_valid = '0;
    logic [7*NUM_CH-1:0]  req_code = '0;
    logic [NUM_CH-1:0]    req_ready;
    logic                 out_valid;
    logic                 out_ready = 1'b1;
    logic [3:0]           out_data;
    logic [CH_W-1:0]      out_ch;
    logic                 out_corrected;
    logic [2:0]           out_syndrome;
    logic                 err_clr = 1'b0;
    logic [CNT_W-1:0]     err_count;

    typedef struct packed {
        logic [CH_W-1:0] ch;
        logic [3:0]      data;
        logic [2:0]      syn;
        logic            corr;
    } exp_t;

    exp_t sb[$];
    int   hs_q[$];
    int   cyc = 0;
    int   n_assert = 0;
    int   n_fail = 0;
    logic prev_valid = 1'b0;

    hamming_decode_arbiter #(
        .NUM_CH (NUM_CH),
        .CNT_W  (CNT_W)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .req_valid     (req_valid),
        .req_code      (req_code),
        .req_ready     (req_ready),
        .out_valid     (out_valid),
        .out_ready     (out_ready),
        .out_data      (out_data),
        .out_ch        (out_ch),
        .out_corrected (out_corrected),
        .out_syndrome  (out_syndrome),
        .err_clr       (err_clr),
        .err_count     (err_count)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [6:0] enc(input logic [3:0] d);
        logic d1, d2, d3, d4;
        d1 = d[3]; d2 = d[2]; d3 = d[1]; d4 = d[0];
        return {d1 ^ d2 ^ d4, d1 ^ d3 ^ d4, d1, d2 ^ d3 ^ d4, d2, d3, d4};
    endfunction

    // Flip Hamming position p (1..7); p = 0 leaves the word clean.
    function automatic logic [6:0] flip(input logic [6:0] c, input int p);
        return (p == 0) ? c : (c ^ (7'd1 << (7 - p)));
    endfunction

    function automatic int oh_idx(input logic [NUM_CH-1:0] v);
        for (int i = 0; i < NUM_CH; i++) if (v[i]) return i;
        return -1;
    endfunction

    task automatic expect_word(input int ch, input logic [3:0] d, input int p);
        exp_t e;
        e.ch   = CH_W'(ch);
        e.data = d;
        e.syn  = 3'(p);
        e.corr = (p != 0);
        sb.push_back(e);
    endtask

    task automatic wait_grant(input int ch);
        bit seen = 1'b0;
        for (int i = 0; i < 40 && !seen; i++) begin
            @(negedge clk);
            seen = req_valid[ch] && req_ready[ch];
        end
        if (!seen) check("grant_timeout", 32'(req_ready), 32'(1 << ch));
    endtask

    // Offer one codeword on a channel, hold until granted, then drop valid.
    task automatic send(input int ch, input logic [6:0] code);
        req_code[7*ch +: 7] = code;
        req_valid[ch] = 1'b1;
        wait_grant(ch);
        @(posedge clk); #1;
        req_valid[ch] = 1'b0;
    endtask

    task automatic send_word(input int ch, input logic [3:0] d, input int p);
        expect_word(ch, d, p);
        send(ch, flip(enc(d), p));
    endtask

    task automatic wait_valid();
        bit seen = 1'b0;
        for (int i = 0; i < 20 && !seen; i++) begin
            @(negedge clk);
            seen = out_valid;
        end
        if (!seen) check("valid_timeout", 32'(out_valid), 32'd1);
    endtask

    task automatic drain();
        for (int i = 0; i < 200 && (sb.size() != 0 || out_valid); i++) @(negedge clk);
        check("drain", 32'(sb.size()), 32'd0);
        @(posedge clk); #1;
    endtask

    // Output monitor: grant legality, N+2 latency and scoreboard compare.
    always @(negedge clk) begin
        if (!rst) begin
            if (req_ready != '0) begin
                check("grant_onehot", 32'($onehot(req_ready)), 32'd1);
                check("grant_subset", 32'(req_ready & ~req_valid), 32'd0);
            end
            if (|(req_valid & req_ready)) hs_q.push_back(cyc);
            if (out_valid && !prev_valid) begin
                if (hs_q.size() == 0) check("latency_orphan", 32'(hs_q.size()), 32'd1);
                else check("latency", 32'(cyc - hs_q.pop_front()), 32'd2);
            end
            if (out_valid && out_ready) begin
                if (sb.size() == 0) begin
                    check("sb_underflow", 32'(sb.size()), 32'd1);
                end else begin
                    exp_t e;
                    e = sb.pop_front();
                    check("out_ch", 32'(out_ch), 32'(e.ch));
                    check("out_data", 32'(out_data), 32'(e.data));
                    check("out_syndrome", 32'(out_syndrome), 32'(e.syn));
                    check("out_corrected", 32'(out_corrected), 32'(e.corr));
                end
            end
        end
        prev_valid = out_valid;
    end

    initial begin
        int order[14] = '{0, 1, 2, 3, 0, 1, 2, 3, 0, 2, 3, 0, 2, 3};
        int last_cyc;
        bit seen;

        // Reset state, with every channel requesting during reset.
        rst = 1'b1;
        req_valid = '1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_req_ready", 32'(req_ready), 32'd0);
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_out_data", 32'(out_data), 32'd0);
        check("rst_out_ch", 32'(out_ch), 32'd0);
        check("rst_out_corrected", 32'(out_corrected), 32'd0);
        check("rst_out_syndrome", 32'(out_syndrome), 32'd0);
        check("rst_err_count", 32'(err_count), 32'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        req_valid = '0;

        // Clean word and a position-5 error.
        expect_word(0, 4'b1011, 0);
        send(0, 7'h33);
        drain();
        check("err_after_clean", 32'(err_count), 32'd0);
        expect_word(1, 4'b1011, 5);
        send(1, 7'h37);
        drain();
        check("err_after_single", 32'(err_count), 32'd1);

        err_clr = 1'b1;
        @(posedge clk); #1;
        err_clr = 1'b0;
        check("err_clr", 32'(err_count), 32'd0);

        // Every data value, clean and with each single-bit flip.
        for (int d = 0; d < 16; d++) begin
            for (int p = 0; p < 8; p++) begin
                send_word((d * 8 + p) % NUM_CH, 4'(d), p);
            end
        end
        drain();
        check("err_exhaustive", 32'(err_count), 32'd112);

        // Saturation at all-ones.
        for (int i = 0; i < 15; i++) send_word(i % NUM_CH, 4'(i), (i % 7) + 1);
        drain();
        check("err_full", 32'(err_count), 32'd127);
        for (int i = 0; i < 2; i++) send_word(i, 4'(i + 3), 2);
        drain();
        check("err_saturated", 32'(err_count), 32'd127);

        // Backpressure: 10 stalled cycles in OUT with another channel requesting.
        out_ready = 1'b0;
        send_word(2, 4'd9, 3);
        req_code[6:0] = enc(4'd6);
        req_valid[0] = 1'b1;
        expect_word(0, 4'd6, 0);
        @(posedge clk);
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            check("stall_valid", 32'(out_valid), 32'd1);
            check("stall_data", 32'(out_data), 32'd9);
            check("stall_syndrome", 32'(out_syndrome), 32'd3);
            check("stall_corrected", 32'(out_corrected), 32'd1);
            check("stall_ch", 32'(out_ch), 32'd2);
            check("stall_req_ready", 32'(req_ready), 32'd0);
        end
        @(posedge clk); #1;
        out_ready = 1'b1;
        wait_grant(0);
        @(posedge clk); #1;
        req_valid[0] = 1'b0;
        drain();

        // Clear coincident with a corrected output transfer.
        out_ready = 1'b0;
        send_word(1, 4'd3, 7);
        wait_valid();
        check("err_pre_clr", 32'(err_count), 32'd127);
        @(posedge clk); #1;
        out_ready = 1'b1;
        err_clr = 1'b1;
        @(posedge clk); #1;
        err_clr = 1'b0;
        check("err_clr_wins", 32'(err_count), 32'd0);
        check("clr_xfer_done", 32'(out_valid), 32'd0);
        drain();

        // Reset while in DEC; afterwards ptr must be back at 0.
        expect_word(1, 4'd5, 0);
        send(1, enc(4'd5));
        rst = 1'b1;
        req_code[6:0]   = enc(4'd2);
        req_code[27:21] = enc(4'd12);
        req_valid = 4'b1001;
        @(negedge clk);
        check("rst_dec_no_grant", 32'(req_ready), 32'd0);
        @(posedge clk); #1;
        check("rst_dec_valid", 32'(out_valid), 32'd0);
        rst = 1'b0;
        sb.delete();
        hs_q.delete();
        expect_word(0, 4'd2, 0);
        @(negedge clk);
        check("rst_ptr_grant", 32'(req_ready), 32'b0001);
        @(posedge clk); #1;
        req_valid = '0;
        drain();

        // Reset while in OUT with out_ready raised in the same cycle.
        out_ready = 1'b0;
        send_word(2, 4'd7, 4);
        wait_valid();
        @(posedge clk); #1;
        rst = 1'b1;
        out_ready = 1'b1;
        @(negedge clk);
        @(posedge clk); #1;
        check("rst_out_valid_drop", 32'(out_valid), 32'd0);
        check("rst_out_data_zero", 32'(out_data), 32'd0);
        check("rst_out_err_zero", 32'(err_count), 32'd0);
        rst = 1'b0;
        sb.delete();
        hs_q.delete();

        // Fairness: all channels valid, then ch1 drops out.
        for (int r = 0; r < 2; r++) for (int c = 0; c < NUM_CH; c++) expect_word(c, 4'(c + 4), 0);
        for (int r = 0; r < 2; r++) begin
            expect_word(0, 4'd4, 0);
            expect_word(2, 4'd6, 0);
            expect_word(3, 4'd7, 0);
        end
        for (int c = 0; c < NUM_CH; c++) req_code[7*c +: 7] = enc(4'(c + 4));
        req_valid = '1;
        last_cyc = 0;
        for (int g = 0; g < 14; g++) begin
            seen = 1'b0;
            for (int i = 0; i < 20 && !seen; i++) begin
                @(negedge clk);
                seen = |(req_valid & req_ready);
            end
            if (!seen) check("fair_timeout", 32'(req_ready), 32'(1 << order[g]));
            check("fair_order", 32'(oh_idx(req_ready)), 32'(order[g]));
            if (g > 0) check("fair_gap", 32'(cyc - last_cyc), 32'd3);
            last_cyc = cyc;
            if (g == 7) begin
                @(posedge clk); #1;
                req_valid[1] = 1'b0;
            end
        end
        @(posedge clk); #1;
        req_valid = '0;
        drain();

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule

// File: doc/hamming_decode_arbiter.md
# hamming_decode_arbiter

Shares one Hamming (7,4) decode/correct datapath between `NUM_CH` receive channels. Each channel offers a 7-bit codeword over a valid/ready handshake. A round-robin arbiter picks one channel, the word is registered, and the syndrome is computed and any single-bit error corrected. The 4-bit data word is then presented on a single valid/ready output tagged with its source channel, and the block keeps a saturating count of corrected words.

## Interface
- `NUM_CH`, default 4: number of requesting channels; legal range 2..8.
- `CNT_W`, default 16: width of the corrected-word counter.
- `clk` in 1: single clock; all logic on the rising edge.
- `rst` in 1: synchronous, active-high reset.
- `req_valid` in `NUM_CH`: per-channel codeword valid.
- `req_code` in `7*NUM_CH`: channel k occupies bits `[7k+6:7k]`.
- `req_ready` out `NUM_CH`: one-hot grant; a transfer occurs when `req_valid[k] & req_ready[k]`.
- `out_valid` out 1: decoded word available.
- `out_ready` in 1: downstream accepts.
- `out_data` out 4: corrected data, ordered `{D1,D2,D3,D4}`.
- `out_ch` out `$clog2(NUM_CH)`: index of the source channel.
- `out_corrected` out 1: syndrome was non-zero and one bit was flipped.
- `out_syndrome` out 3: raw syndrome `{s4,s2,s1}`.
- `err_clr` in 1: clears `err_count`.
- `err_count` out `CNT_W`: saturating count of transferred words with `out_corrected=1`.

## Operation
- Codeword layout: `code[7-p]` holds position p (p = 1..7).
  - Bits are `code[6]=P1`, `[5]=P2`, `[4]=D1`, `[3]=P4`, `[2]=D2`, `[1]=D3`, `[0]=D4`.
- Syndrome:
  - `s1 = c6^c4^c2^c0`
  - `s2 = c5^c4^c1^c0`
  - `s4 = c3^c2^c1^c0`
  - Syndrome s ≠ 0 inverts `code[7-s]`; s = 0 passes the word through.
  - Data output is `{c[4],c[2],c[1],c[0]}` after correction.
- Double errors are not detected; they decode as a miscorrected single error. This is by design.
- FSM states: `IDLE`, `DEC`, `OUT`.
  - `IDLE`: if any `req_valid` is set, assert `req_ready` for the granted channel g in the same cycle, latch `req_code[g]` and g, and go to `DEC`. Otherwise stay in `IDLE` with `req_ready = 0`.
  - `DEC`: register the decode results into the `out_*` registers, set `out_valid`, and go to `OUT`. `req_ready = 0`.
  - `OUT`: hold all `out_*` stable. When `out_ready` is high, clear `out_valid`, update `err_count`, and go to `IDLE`. `req_ready = 0`.
- Round-robin arbitration:
  - Search starts at pointer `ptr` and moves upward with wrap-around (k = ptr, ptr+1, … mod `NUM_CH`).
  - On a grant, `ptr` becomes (g+1) mod `NUM_CH`.
  - `ptr` is unchanged when there is no grant.
- `req_ready` depends combinationally on `req_valid` and state, and is never asserted to a channel whose `req_valid` is low.
- `err_count`:
  - Increments by 1 on an output transfer with `out_corrected=1`.
  - Holds at all-ones (saturates).
  - When `err_clr` and an increment occur in the same cycle, clear wins and the result is 0.
- Reset values: state `IDLE`, `ptr=0`, `req_ready=0`, `out_valid=0`, `out_data=0`, `out_ch=0`, `out_corrected=0`, `out_syndrome=0`, `err_count=0`.
- Reset mid-operation drops the captured or presented word. No handshake completes in a cycle where `rst=1`.

## Timing
- Input handshake in cycle N → `out_valid` high from cycle N+2.
- With `out_ready` held high, `out_valid` lasts 1 cycle (N+2) and the next grant can occur at N+3. Maximum throughput is 1 word per 3 cycles.
- `out_ready` low stalls indefinitely in `OUT`, with outputs stable and no new grants.
- `req_valid` may drop while not granted; channels are not required to hold valid.

## Structure
- Package `hamming_pkg` contains:
  - The FSM state enum.
  - Codeword bit-position constants (`P1_BIT=6` … `D4_BIT=0`).
  - A `syndrome74` function shared with the transmit-side encoder.
- Sub-module `hamming74_decode` (combinational):
  - Input: 7-bit code.
  - Outputs: 4-bit data, 3-bit syndrome, corrected flag.
  - Instantiated once, between the capture register and the output registers.
- All arbitration, FSM, and counter logic lives in the top module.

## Test plan
- Clean word: ch0 sends `0x33` (data 1011) → `out_data=4'b1011`, `out_syndrome=0`, `out_corrected=0`, `out_ch=0`, `out_valid` at N+2.
- Single error: ch1 sends `0x37` (position 5 flipped) → `out_syndrome=3'd5`, `out_data=4'b1011`, `out_corrected=1`, `err_count` goes 0→1 on the output transfer.
- Exhaustive: every 4-bit data value × each of the 7 single-bit flips, plus the clean word → correct data every time; `err_count=112` afterwards.
- Fairness: all 4 channels hold valid continuously → grants in order 0,1,2,3,0,… Then drop ch1 → order skips ch1 with no stall cycles.
- Backpressure: `out_ready=0` for 10 cycles in `OUT` → outputs stable, `req_ready` stays 0. Force `err_count` to all-ones → stays at all-ones. `err_clr` with a simultaneous corrected transfer → 0.
- Reset in `DEC` or `OUT` → next cycle `out_valid=0`, state `IDLE`, `ptr=0`, and no transfer completes during the reset cycle.
